// File: rtl/bp_skid_fifo.sv
// Skid FIFO for NoC router ports: absorbs in-flight flits under same-cycle downstream
// backpressure and presents registered backpressure upstream, with optional bypass.
module bp_skid_fifo #(
    parameter int D_W    = 32,
    parameter int A_W    = 32,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_v,
    input  logic [A_W+D_W:0]             i_d,
    output logic                         i_b,
    output logic                         o_v,
    output logic [A_W+D_W:0]             o_d,
    input  logic                         o_b,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);
    localparam int W  = A_W + D_W + 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [OW-1:0] occ_next;
    logic          empty;
    logic          in_fire;
    logic          out_fire;
    logic          bypass_take;
    logic          enq;
    logic          deq;

    // A flit goes straight through only when storage is empty and downstream takes it now.
    always_comb begin
        empty       = (occ == '0);
        in_fire     = i_v & ~i_b;
        bypass_take = empty & BYPASS & ~o_b;
        o_d         = empty ? i_d : mem[head];
        if (rst) begin
            o_v = 1'b0;
        end else if (!empty) begin
            o_v = 1'b1;
        end else begin
            o_v = BYPASS & in_fire;
        end
        out_fire = o_v & ~o_b;
        enq      = in_fire & ~bypass_take;
        deq      = out_fire & ~empty;
        occ_next = occ + OW'(enq) - OW'(deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            i_b  <= 1'b1;
        end else begin
            if (deq) begin
                head <= (head == LAST) ? '0 : head + PW'(1);
            end
            if (enq) begin
                tail <= (tail == LAST) ? '0 : tail + PW'(1);
            end
            occ <= occ_next;
            i_b <= (occ_next == FULL);
        end
    end

    // Payload storage is deliberately left unreset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= i_d;
        end
    end
endmodule
